// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the fixed-latency word memory responder.
package mem_responder_pkg;

  localparam int LATENCY_DEFAULT = 2;
  localparam int DEPTH_DEFAULT   = 256;
  localparam int CNT_W           = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a CPU-side initiator and the memory responder.
interface mem_responder_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        addr_err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy, addr_err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy, addr_err
  );

endinterface

// File: rtl/mem_responder_array.sv
// Byte-wide storage with a 4-byte big-endian read port and 4-byte write port.
// Contents are deliberately not reset so they survive a responder reset.
module mem_byte_array
  import mem_responder_pkg::*;
#(
  parameter  int DEPTH_BYTES = DEPTH_DEFAULT,
  localparam int IDX_W       = $clog2(DEPTH_BYTES)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  logic [IDX_W-1:0] idx1, idx2, idx3;

  // Index arithmetic wraps naturally at the array size.
  assign idx1 = idx + IDX_W'(1);
  assign idx2 = idx + IDX_W'(2);
  assign idx3 = idx + IDX_W'(3);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx]  <= wdata[31:24];
      mem[idx1] <= wdata[23:16];
      mem[idx2] <= wdata[15:8];
      mem[idx3] <= wdata[7:0];
    end
  end

  assign rdata = {mem[idx], mem[idx1], mem[idx2], mem[idx3]};

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder: accepts one request, waits LATENCY
// cycles, performs the access and pulses ack for one cycle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY     = LATENCY_DEFAULT,
  parameter int DEPTH_BYTES = DEPTH_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int   IDX_W    = $clog2(DEPTH_BYTES);
  localparam cnt_t CNT_LOAD = cnt_t'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..15");
  end
  if (DEPTH_BYTES < 4 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
    $error("mem_responder: DEPTH_BYTES must be a power of two, at least 4");
  end

  state_t           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             capture, access;
  logic [IDX_W-1:0] idx_q;
  logic             misaligned_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [31:0]      mem_rdata;
  logic             mem_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      misaligned_q <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q        <= bus.addr[IDX_W-1:0];
        misaligned_q <= (bus.addr[1:0] != 2'b00);
        we_q         <= bus.we;
        wdata_q      <= bus.wdata;
      end
      if (access) begin
        err_q   <= misaligned_q;
        rdata_q <= misaligned_q ? 32'h0 : (we_q ? wdata_q : mem_rdata);
      end
    end
  end

  // req is only looked at in IDLE, so it is ignored while a transaction runs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          capture = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_t'(1);
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_we = access & we_q & ~misaligned_q;

  mem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign bus.ack      = (state_q == RESP);
  assign bus.busy     = (state_q != IDLE);
  assign bus.addr_err = (state_q == RESP) & err_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one instance at LATENCY=2
// for the functional vectors, one at LATENCY=1 for back-to-back traffic.
module tb_mem_responder;

  logic clk;
  logic reset;
  int   tests;
  int   failures;

  mem_responder_if bus();
  mem_responder_if bus1();

  mem_responder #(.LATENCY(2), .DEPTH_BYTES(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_responder #(.LATENCY(1), .DEPTH_BYTES(256)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one transaction on the LATENCY=2 instance; operands are scrambled
  // right after acceptance so captured values are what the access uses.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output logic err,
                               output int lat, output logic busy_seen);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.req   = 1'b0;
    bus.we    = ~w;
    bus.addr  = a ^ 32'h0000_00FC;
    bus.wdata = ~d;
    busy_seen = bus.busy;
    lat = -1;
    rd  = 32'h0;
    err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack) begin
        lat = i;
        rd  = bus.rdata;
        err = bus.addr_err;
        break;
      end
    end
  endtask

  task automatic runTxn(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        busy_seen;
    applyStimulus(w, a, d, rd, err, lat, busy_seen);
    checkOutput({tag, "_busy"}, 32'(busy_seen), 32'd1);
    checkOutput({tag, "_lat"}, 32'(lat), 32'd2);
    checkOutput({tag, "_rdata"}, rd, exp_rd);
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    @(posedge clk);
    #1;
    checkOutput({tag, "_ack_drop"}, 32'(bus.ack), 32'd0);
    checkOutput({tag, "_err_idle"}, 32'(bus.addr_err), 32'd0);
    checkOutput({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_rdata_hold"}, bus.rdata, exp_rd);
  endtask

  initial begin
    int acks;
    tests     = 0;
    failures  = 0;
    reset     = 1'b0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    bus1.req   = 1'b0;
    bus1.we    = 1'b0;
    bus1.addr  = 32'h0;
    bus1.wdata = 32'h0;

    #1 reset = 1'b1;
    #2;
    checkOutput("rst_ack", 32'(bus.ack), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_err", 32'(bus.addr_err), 32'd0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    runTxn("wr10", 1'b1, 32'h10, 32'h1234_5678, 32'h1234_5678, 1'b0);
    runTxn("rd10", 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0);
    checkOutput("byte10", 32'(dut.u_mem.mem[8'h10]), 32'h12);
    checkOutput("byte13", 32'(dut.u_mem.mem[8'h13]), 32'h78);

    runTxn("wr20", 1'b1, 32'h20, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0);
    runTxn("wr21_mis", 1'b1, 32'h21, 32'hFFFF_FFFF, 32'h0, 1'b1);
    runTxn("rd20", 1'b0, 32'h20, 32'h0, 32'hA5A5_0F0F, 1'b0);
    runTxn("rd22_mis", 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);

    runTxn("wr104", 1'b1, 32'h104, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0);
    runTxn("rd04", 1'b0, 32'h04, 32'h0, 32'hCAFE_BABE, 1'b0);

    // Abort a write while it sits in WAIT.
    runTxn("wr30", 1'b1, 32'h30, 32'h1122_3344, 32'h1122_3344, 1'b0);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h30;
    bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    checkOutput("abort_busy_pre", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_ack", 32'(bus.ack), 32'd0);
    checkOutput("abort_rdata", bus.rdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack) acks++;
    end
    checkOutput("abort_no_ack", 32'(acks), 32'd0);
    runTxn("rd30", 1'b0, 32'h30, 32'h0, 32'h1122_3344, 1'b0);
    runTxn("rd10_keep", 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0);

    // Back-to-back at LATENCY=1: WAIT, RESP, IDLE repeating from acceptance.
    bus1.req   = 1'b1;
    bus1.we    = 1'b1;
    bus1.addr  = 32'h40;
    bus1.wdata = 32'h0BAD_F00D;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("b2b_ack%0d", k), 32'(bus1.ack), 32'((k % 3) == 1));
      checkOutput($sformatf("b2b_busy%0d", k), 32'(bus1.busy), 32'((k % 3) != 2));
      if ((k % 3) == 1)
        checkOutput($sformatf("b2b_rdata%0d", k), bus1.rdata, 32'h0BAD_F00D);
    end
    bus1.req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
